hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side hazard tracker for the 5-stage RISC-V pipeline. It records every in-flight register write from issue (ID->EX) until writeback.
- It tells ID when a source operand cannot yet be supplied by the EX/MEM or MEM/WB bypass, covering load-use and long-latency mul/div results, and raises a stall.
- Sits beside the decode stage, opposite the bypass-data consumer in EX.

Parameters:
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.
- CNT_W, 2, width of the per-register forwardability countdown.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- freeze  input  1  pipeline frozen (D-cache/I-cache stall); all state holds
- issue_valid  input  1  instruction moves ID->EX this cycle
- issue_rd  input  5  destination register
- issue_we  input  1  instruction writes rd
- issue_kind  input  2  0=ALU/JAL, 1=LOAD, 2=LONG (mul/div), 3=reserved (treated as ALU)
- flush  input  1  instruction currently in EX is killed (branch mispredict)
- long_done  input  1  long-latency unit result enters MEM this cycle
- long_rd  input  5  rd of completing long op
- wb_valid  input  1  writeback of wb_rd this cycle
- wb_rd  input  5  writeback register
- id_rs1, id_rs2  input  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  input  1 each  instruction in ID actually reads that source
- hazard_stall  output  1  hold PC and IF/ID, insert bubble into ID/EX
- busy_vec  output  NUM_REGS  per-register pending-write bits (debug/verification)

Behaviour:
- Reset: all entries cleared (busy=0, cnt=0, long=0), restore register invalid. hazard_stall=0, busy_vec=0. All updates are registered on the rising clk edge; outputs are combinational from state and ID inputs.
- Entry per register r (1..31): busy, long, cnt[CNT_W-1:0].
- Issue (issue_valid & issue_we & issue_rd!=0 & !freeze): entry <= busy=1.
  - ALU: cnt=0, long=0.
  - LOAD: cnt=1, long=0.
  - LONG: cnt=0, long=1.
  - Before overwriting, the prior entry (cnt already decremented) and rd are saved in a one-deep restore register, marked valid. Any other issue_valid invalidates the restore register.
- Countdown: each cycle without freeze, every entry with cnt!=0 decrements by 1. A newly issued entry is loaded, not decremented, in its issue cycle.
- long_done & long_rd match & !freeze: long<=0.
- Writeback (wb_valid & !freeze): busy<=0 for wb_rd, unless the same cycle issues to the same rd, in which case the issue wins.
- Flush (!freeze): if restore is valid, the entry for restore rd is rewritten with the saved, decremented prior state. Flush overrides wb for that rd. Restore is then invalid. flush & issue_valid in the same cycle: flush is applied first, then the issue.
- hazard_stall = OR over s in {rs1, rs2} of:
  - id_use_s & s!=0 & busy[s] & (cnt[s]!=0 | long[s])
  - Evaluated combinationally. Forced 0 while flush=1, since ID contents are being killed.
- freeze: no state changes at all; hazard_stall is still driven from current state.
- x0: issue/wb to rd=0 ignored; busy_vec[0] always 0.
- Reset asserted mid-operation clears all state on the next edge regardless of other inputs.
- Latency:
  - ALU producer: zero stall cycles.
  - LOAD producer: one stall cycle for the dependent instruction immediately behind it.
  - LONG producer: stall until long_done is registered.

Optional Feature:
- SCOREBOARD_STATS_EN
  - Defined: adds output stall_cycles (32 bits), which counts cycles with hazard_stall=1 & !freeze. It saturates at 0xFFFFFFFF and resets to 0.
  - Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: issue LOAD rd=5; next cycle ID reads rs1=5 (use=1) -> hazard_stall=1 exactly one cycle, then 0. busy_vec[5]=1 until wb_rd=5.
- ALU back-to-back: issue ALU rd=7; next cycle rs2=7 -> hazard_stall=0 throughout.
- Long op: issue LONG rd=10; ID rs1=10 -> stall held 6 cycles until long_done rd=10, drops the following cycle. wb_rd=10 then clears busy_vec[10].
- Flush restore: LOAD rd=3, then ALU rd=3, then flush -> entry 3 restored as busy LOAD with cnt=0. Next wb_rd=3 clears it; no stall from the killed ALU.
- Freeze: LOAD rd=4, freeze=1 for 3 cycles with rs1=4 -> stall stays 1 and cnt is unchanged. After freeze drops, stall clears after 1 cycle.
- x0 and reset: issue LOAD rd=0 -> busy_vec=0, no stall. Assert rst_n=0 with 5 busy entries -> busy_vec=0 and hazard_stall=0 on the next edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline control and the hazard scoreboard.
// The pipeline drives through the master modport; the scoreboard uses the slave modport.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned RegW = $clog2(NUM_REGS);

  logic                freeze;
  logic                issue_valid;
  logic [RegW-1:0]     issue_rd;
  logic                issue_we;
  logic [1:0]          issue_kind;
  logic                flush;
  logic                long_done;
  logic [RegW-1:0]     long_rd;
  logic                wb_valid;
  logic [RegW-1:0]     wb_rd;
  logic [RegW-1:0]     id_rs1;
  logic [RegW-1:0]     id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                hazard_stall;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output freeze, issue_valid, issue_rd, issue_we, issue_kind, flush,
           long_done, long_rd, wb_valid, wb_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  hazard_stall, busy_vec
  );

  modport slave (
    input  freeze, issue_valid, issue_rd, issue_we, issue_kind, flush,
           long_done, long_rd, wb_valid, wb_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output hazard_stall, busy_vec
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes from issue to writeback and stalls ID on unforwardable sources.
// Optional stall_cycles counter when SCOREBOARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  sb
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);
  localparam int unsigned RegW = $clog2(NUM_REGS);
  localparam logic [1:0] KindLoad = 2'd1;
  localparam logic [1:0] KindLong = 2'd2;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] long_q, long_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];

  logic                rs_valid_q, rs_valid_d;
  logic [RegW-1:0]     rs_rd_q, rs_rd_d;
  logic                rs_busy_q, rs_busy_d;
  logic                rs_long_q, rs_long_d;
  logic [CNT_W-1:0]    rs_cnt_q, rs_cnt_d;

  logic issue_ok;
  logic stall1, stall2, stall;

  assign issue_ok = sb.issue_valid && sb.issue_we && (sb.issue_rd != '0);

  // Update order: countdown, long completion, writeback, flush restore, then issue.
  always_comb begin
    busy_d     = busy_q;
    long_d     = long_q;
    cnt_d      = cnt_q;
    rs_valid_d = rs_valid_q;
    rs_rd_d    = rs_rd_q;
    rs_busy_d  = rs_busy_q;
    rs_long_d  = rs_long_q;
    rs_cnt_d   = rs_cnt_q;
    if (!sb.freeze) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      if (sb.long_done && sb.long_rd != '0) long_d[sb.long_rd] = 1'b0;
      if (sb.wb_valid && sb.wb_rd != '0) busy_d[sb.wb_rd] = 1'b0;
      if (sb.flush) begin
        if (rs_valid_q) begin
          busy_d[rs_rd_q] = rs_busy_q;
          long_d[rs_rd_q] = rs_long_q;
          cnt_d[rs_rd_q]  = rs_cnt_q;
        end
        rs_valid_d = 1'b0;
      end
      if (issue_ok) begin
        // Snapshot the displaced entry so a flush of this instruction can undo it.
        rs_valid_d = 1'b1;
        rs_rd_d    = sb.issue_rd;
        rs_busy_d  = busy_d[sb.issue_rd];
        rs_long_d  = long_d[sb.issue_rd];
        rs_cnt_d   = cnt_d[sb.issue_rd];
        busy_d[sb.issue_rd] = 1'b1;
        long_d[sb.issue_rd] = (sb.issue_kind == KindLong);
        cnt_d[sb.issue_rd]  = (sb.issue_kind == KindLoad) ? CNT_W'(1) : '0;
      end else if (sb.issue_valid) begin
        rs_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      long_q     <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      rs_valid_q <= 1'b0;
      rs_rd_q    <= '0;
      rs_busy_q  <= 1'b0;
      rs_long_q  <= 1'b0;
      rs_cnt_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      long_q     <= long_d;
      cnt_q      <= cnt_d;
      rs_valid_q <= rs_valid_d;
      rs_rd_q    <= rs_rd_d;
      rs_busy_q  <= rs_busy_d;
      rs_long_q  <= rs_long_d;
      rs_cnt_q   <= rs_cnt_d;
    end
  end

  always_comb begin
    stall1 = sb.id_use_rs1 && (sb.id_rs1 != '0) && busy_q[sb.id_rs1] &&
             ((cnt_q[sb.id_rs1] != '0) || long_q[sb.id_rs1]);
    stall2 = sb.id_use_rs2 && (sb.id_rs2 != '0) && busy_q[sb.id_rs2] &&
             ((cnt_q[sb.id_rs2] != '0) || long_q[sb.id_rs2]);
    // A flushed ID instruction must not hold the front end.
    stall  = !sb.flush && (stall1 || stall2);
  end

  assign sb.hazard_stall = stall;
  assign sb.busy_vec     = {busy_q[NUM_REGS-1:1], 1'b0};

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && !sb.freeze && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized check of hazard_scoreboard against a per-register reference model.
// Define SCOREBOARD_STATS_EN to also check the stall_cycles counter.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if sb ();
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Reference model: plain per-register arrays updated by the rules in order.
  bit  m_busy [32];
  bit  m_long [32];
  int  m_cnt  [32];
  bit  r_valid;
  int  r_rd;
  bit  r_busy, r_long;
  int  r_cnt;
  longint m_stats;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic bit src_stall(bit use_s, int s);
    return use_s && s != 0 && m_busy[s] && (m_cnt[s] != 0 || m_long[s]);
  endfunction

  function automatic bit exp_stall();
    if (sb.flush) return 1'b0;
    return src_stall(sb.id_use_rs1, int'(sb.id_rs1)) || src_stall(sb.id_use_rs2, int'(sb.id_rs2));
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 0; m_long[r] = 0; m_cnt[r] = 0;
    end
    r_valid = 0; r_rd = 0; r_busy = 0; r_long = 0; r_cnt = 0;
    m_stats = 0;
  endtask

  task automatic model_edge();
    int rd;
    bit st;
    st = exp_stall();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sb.freeze) return;
    if (st && m_stats < 64'hFFFF_FFFF) m_stats++;
    for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
    if (sb.long_done && sb.long_rd != 0) m_long[sb.long_rd] = 0;
    if (sb.wb_valid && sb.wb_rd != 0) m_busy[sb.wb_rd] = 0;
    if (sb.flush) begin
      if (r_valid) begin
        m_busy[r_rd] = r_busy; m_long[r_rd] = r_long; m_cnt[r_rd] = r_cnt;
      end
      r_valid = 0;
    end
    rd = int'(sb.issue_rd);
    if (sb.issue_valid && sb.issue_we && rd != 0) begin
      r_valid = 1; r_rd = rd;
      r_busy = m_busy[rd]; r_long = m_long[rd]; r_cnt = m_cnt[rd];
      m_busy[rd] = 1;
      m_long[rd] = (sb.issue_kind == 2'd2);
      m_cnt[rd]  = (sb.issue_kind == 2'd1) ? 1 : 0;
    end else if (sb.issue_valid) begin
      r_valid = 0;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // lit: -1 = model only, 0/1 = also compare hazard_stall with that fixed value.
  task automatic cycle(int lit = -1);
    @(negedge clk);
    check("stall_vs_model", 32'(sb.hazard_stall), 32'(exp_stall()));
    check("busy_vec_vs_model", sb.busy_vec, exp_busy());
    if (lit >= 0) check("stall_directed", 32'(sb.hazard_stall), 32'(lit));
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, m_stats[31:0]);
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    sb.freeze = 0; sb.issue_valid = 0; sb.issue_rd = 0; sb.issue_we = 0; sb.issue_kind = 0;
    sb.flush = 0; sb.long_done = 0; sb.long_rd = 0; sb.wb_valid = 0; sb.wb_rd = 0;
    sb.id_rs1 = 0; sb.id_rs2 = 0; sb.id_use_rs1 = 0; sb.id_use_rs2 = 0;
  endtask

  task automatic issue(int rd, int kind);
    sb.issue_valid = 1; sb.issue_we = 1; sb.issue_rd = 5'(rd); sb.issue_kind = 2'(kind);
  endtask

  task automatic read_rs1(int rs);
    sb.issue_valid = 0; sb.issue_we = 0; sb.id_rs1 = 5'(rs); sb.id_use_rs1 = 1;
  endtask

  initial begin
    model_reset();
    idle();
    rst_n = 0;
    #1;
    cycle(); cycle();
    rst_n = 1;
    sb.id_rs1 = 5'd1; sb.id_use_rs1 = 1;
    cycle(0);
    check("reset_busy_vec", sb.busy_vec, 32'h0);

    // Load-use: one stall cycle, busy until writeback.
    idle(); issue(5, 1); cycle();
    read_rs1(5); cycle(1);
    cycle(0);
    check("load_busy5", 32'(sb.busy_vec[5]), 32'd1);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd5; cycle();
    check("load_wb_clear5", 32'(sb.busy_vec[5]), 32'd0);

    // ALU back-to-back: never stalls.
    idle(); issue(7, 0); cycle(0);
    idle(); sb.id_rs2 = 5'd7; sb.id_use_rs2 = 1; cycle(0); cycle(0);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd7; cycle();

    // Long op: held until long_done is registered.
    idle(); issue(10, 2); cycle();
    read_rs1(10);
    for (int i = 0; i < 6; i++) cycle(1);
    sb.long_done = 1; sb.long_rd = 5'd10; cycle(1);
    sb.long_done = 0; cycle(0);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd10; cycle();
    check("long_wb_clear10", 32'(sb.busy_vec[10]), 32'd0);

    // Flush restore: killed ALU rd=3 rolls back to the older LOAD.
    idle(); issue(3, 1); cycle();
    issue(3, 0); cycle();
    idle(); sb.flush = 1; cycle(0);
    idle(); read_rs1(3); cycle(0);
    check("flush_restored_busy3", 32'(sb.busy_vec[3]), 32'd1);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd3; cycle();
    check("flush_wb_clear3", 32'(sb.busy_vec[3]), 32'd0);

    // Freeze holds the countdown.
    idle(); issue(4, 1); cycle();
    read_rs1(4); sb.freeze = 1;
    for (int i = 0; i < 3; i++) cycle(1);
    sb.freeze = 0; cycle(1); cycle(0);
    idle(); sb.wb_valid = 1; sb.wb_rd = 5'd4; cycle();

    // x0 never tracked.
    idle(); issue(0, 1); cycle();
    read_rs1(0); cycle(0);
    check("x0_busy_vec", sb.busy_vec, 32'h0);

    // Reset mid-operation with five busy entries.
    for (int r = 11; r < 16; r++) begin
      idle(); issue(r, 2); cycle();
    end
    check("five_busy", sb.busy_vec, 32'h0000_F800);
    idle(); issue(20, 1); rst_n = 0; cycle();
    rst_n = 1; idle(); read_rs1(12); cycle(0);
    check("midreset_busy_vec", sb.busy_vec, 32'h0);

    // Randomized traffic over a small register window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      sb.freeze      = ($urandom_range(0, 9) == 0);
      sb.issue_valid = ($urandom_range(0, 1) == 1);
      sb.issue_we    = ($urandom_range(0, 5) != 0);
      sb.issue_rd    = 5'($urandom_range(0, 7));
      sb.issue_kind  = 2'($urandom_range(0, 3));
      sb.flush       = ($urandom_range(0, 7) == 0);
      sb.long_done   = ($urandom_range(0, 4) == 0);
      sb.long_rd     = 5'($urandom_range(0, 7));
      sb.wb_valid    = ($urandom_range(0, 2) == 0);
      sb.wb_rd       = 5'($urandom_range(0, 7));
      sb.id_rs1      = 5'($urandom_range(0, 7));
      sb.id_rs2      = 5'($urandom_range(0, 7));
      sb.id_use_rs1  = ($urandom_range(0, 3) != 0);
      sb.id_use_rs2  = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
